spike_aer_encoder: RTL

Consumes the per-cycle spike vector produced by the LIF neuron array and serialises it into address-event (AER) packets of {neuron index, timestamp}. Packets leave on a valid/ready stream toward the routing/readout fabric. Per-neuron pending flags absorb bursts, and a lowest-index-first arbiter feeds a small event FIFO. Spikes that cannot be buffered are dropped and counted.

---
 rtl/spike_aer_encoder_if.sv | 18 +
 rtl/spike_aer_encoder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder_if.sv
// AER output stream interface: valid/ready handshake carrying one
// {neuron index, timestamp} event per transfer.
//   aer_valid : head event present (source -> sink)
//   aer_addr  : neuron index of the head event (source -> sink)
//   aer_ts    : timestamp of the head event (source -> sink)
//   aer_ready : sink accepts the head event this cycle (sink -> source)
interface spike_aer_encoder_if #(
  parameter int AW   = 2,
  parameter int TS_W = 8
);
  logic            aer_valid;
  logic [AW-1:0]   aer_addr;
  logic [TS_W-1:0] aer_ts;
  logic            aer_ready;

  modport master (output aer_valid, output aer_addr, output aer_ts, input aer_ready);
  modport slave  (input aer_valid, input aer_addr, input aer_ts, output aer_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// Spike-vector to AER packet serialiser.
// Each neuron has a pending flag plus captured timestamp. A lowest-index-first
// arbiter moves one pending event per cycle into a DEPTH-entry FIFO, whose head
// is presented on the AER stream. Spikes arriving while the neuron's previous
// event is still pending (and not being granted) are dropped and counted.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   spike_in   : per-neuron single-cycle spike pulses
//   tick       : advance the timestamp counter this cycle
//   aer        : AER output stream (master side)
//   drop_count : number of lost spikes, saturating at 255
//   busy       : any pending flag set or FIFO non-empty
module spike_aer_encoder #(
  parameter int N     = 4,
  parameter int AW    = 2,
  parameter int TS_W  = 8,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         spike_in,
  input  logic                 tick,
  spike_aer_encoder_if.master  aer,
  output logic [7:0]           drop_count,
  output logic                 busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0]    pending_q, pending_d;
  logic [TS_W-1:0] ts_cap_q [N];
  logic [TS_W-1:0] ts_cap_d [N];
  logic [TS_W-1:0] ts_q, ts_d;
  logic [7:0]      drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   fifo_addr_q [DEPTH];
  logic [TS_W-1:0] fifo_ts_q   [DEPTH];

  logic            grant_any;
  logic [AW-1:0]   grant_idx;
  logic            push;
  logic            pop;
  logic            head_valid;

  assign head_valid = (count_q != '0);

  always_comb begin
    logic granted;
    pending_d = pending_q;
    ts_cap_d  = ts_cap_q;
    drop_d    = drop_q;
    granted   = 1'b0;
    ts_d      = tick ? ts_q + TS_W'(1) : ts_q;

    // Fullness is judged on the count at the start of the cycle, so a
    // same-cycle pop never makes room for this cycle's push.
    grant_any = 1'b0;
    grant_idx = '0;
    if (count_q < CW'(DEPTH)) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (pending_q[i] && !grant_any) begin
          grant_any = 1'b1;
          grant_idx = AW'(i);
        end
      end
    end

    push = grant_any;
    pop  = head_valid && aer.aer_ready;

    // A spike on the neuron being granted re-arms its flag with the new
    // timestamp; the old event still goes to the FIFO from ts_cap_q.
    for (int unsigned i = 0; i < N; i++) begin
      granted = grant_any && (grant_idx == AW'(i));
      if (granted) pending_d[i] = 1'b0;
      if (spike_in[i]) begin
        if (pending_q[i] && !granted) begin
          if (drop_d != '1) drop_d = drop_d + 8'd1;
        end else begin
          pending_d[i] = 1'b1;
          ts_cap_d[i]  = ts_q;
        end
      end
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      ts_q      <= '0;
      drop_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < N; i++) ts_cap_q[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_ts_q[i]   <= '0;
      end
    end else begin
      pending_q <= pending_d;
      ts_q      <= ts_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ts_cap_q  <= ts_cap_d;
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= grant_idx;
        fifo_ts_q[wr_ptr_q]   <= ts_cap_q[grant_idx];
      end
    end
  end

  assign aer.aer_valid = head_valid;
  assign aer.aer_addr  = head_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign aer.aer_ts    = head_valid ? fifo_ts_q[rd_ptr_q]   : '0;
  assign drop_count    = drop_q;
  assign busy          = (|pending_q) || head_valid;

endmodule
